uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the transmit-side counterpart to the team's uart_rx.
- Accepts bytes from on-chip logic over a valid/ready handshake and queues them in an internal FIFO.
- Serialises queued bytes onto the line as 8N1-style frames with configurable stop bits and no parity.
- Used by test harnesses and host-reporting paths that need to stream more than one byte without upstream stalls.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- CLKS_PER_BIT, 1250, clock cycles per bit (12 MHz / 9600 baud); minimum 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_BITS  byte to queue.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept a byte this cycle.
- out  out  1  serial line; idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte currently being shifted.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values (applied asynchronously, all registered):
  - out = 1, in_ready = 0, busy = 0, fifo_count = 0.
  - FSM = IDLE; FIFO pointers = 0.
- in_ready after reset: goes 1 on the first clk edge after rst_n deasserts.
- Handshake:
  - A push occurs on a rising edge where in_valid && in_ready.
  - in_ready is registered and equals (count after this edge < FIFO_DEPTH).
  - in_ready is never combinationally dependent on in_valid.
  - in_data is ignored when in_ready = 0; nothing is dropped silently.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push and pop on the same edge: count unchanged; both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full: count == FIFO_DEPTH, so in_ready = 0 for the next cycle. Exiting full via a pop raises in_ready on the following cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: out = 1. If count != 0, pop on this edge, load the shift register, clear the bit timer, go to START.
  - START: out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: out = shift_reg[0] for CLKS_PER_BIT cycles, then shift right. After bit DATA_BITS-1, go to STOP.
  - STOP: out = 1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
    - if count != 0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Latency:
  - A byte pushed at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1.
  - out falls (start bit) after edge k+1.
- Frame length is exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- out is driven from a register (glitch-free).
- Bit timer: counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- busy = (FSM != IDLE) || (count != 0), registered to track the same edge as the state.
- Reset mid-frame:
  - out returns to 1 immediately; FIFO contents are discarded.
  - The frame is truncated and no partial retransmission occurs after reset.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless stated):
- Single byte: push 0xA5 at edge k -> out low over cycles k+1..k+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; busy falls after 40 cycles; fifo_count back to 0.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; peak fifo_count = 1.
- Full: hold in_valid with 0x11..0x16 while frame 1 is in flight -> 0x11 is shifting, 0x12..0x15 queued, in_ready = 0, 0x16 not accepted; in_ready returns 1 the cycle after 0x12 pops; all accepted bytes appear in order.
- Simultaneous push/pop: push on the exact edge IDLE pops with count = 1 -> count stays 1; no byte lost or duplicated.
- STOP_BITS=2: send 0x3C -> stop high 8 cycles; frame = 44 cycles; self-loopback through uart_rx yields valid with data_out = 0x3C.
- Reset mid-DATA: assert rst_n = 0 during bit 3 with 2 bytes queued -> out = 1, in_ready = 0, fifo_count = 0 immediately; after release, out stays idle and in_ready rises one edge later.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a circular FIFO over valid/ready and are
// serialised LSB first as start/data/stop frames on a registered, idle-high line.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1250,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_reg, state_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic [BW-1:0]          bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [CW-1:0]          count_reg, count_next;
    logic [PW-1:0]          wptr_reg, wptr_next, rptr_reg, rptr_next;
    logic                   out_reg, out_next;
    logic                   ready_reg, ready_next;
    logic                   busy_reg, busy_next;
    logic                   push, pop, bit_end;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    assign push = in_valid && ready_reg;

    // Storage has no reset: contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= in_data;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        pop          = 1'b0;
        bit_end      = (timer_reg == TW'(CLKS_PER_BIT - 1));
        timer_next   = bit_end ? '0 : timer_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (count_reg != '0) begin
                    pop          = 1'b1;
                    shift_next   = mem[rptr_reg];
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == BW'(DATA_BITS - 1)) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                // bit_idx doubles as the stop-bit counter; a waiting byte starts with no idle gap.
                if (bit_end) begin
                    if (bit_idx_reg == BW'(STOP_BITS - 1)) begin
                        bit_idx_next = '0;
                        if (count_reg != '0) begin
                            pop        = 1'b1;
                            shift_next = mem[rptr_reg];
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        count_next = count_reg + CW'(push) - CW'(pop);
        wptr_next  = push ? wptr_reg + 1'b1 : wptr_reg;
        rptr_next  = pop  ? rptr_reg + 1'b1 : rptr_reg;
        ready_next = (count_next < CW'(FIFO_DEPTH));
        busy_next  = (state_next != IDLE) || (count_next != '0);

        if (state_next == START) begin
            out_next = 1'b0;
        end else if (state_next == DATA) begin
            out_next = shift_next[0];
        end else begin
            out_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            count_reg   <= '0;
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            out_reg     <= 1'b1;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            count_reg   <= count_next;
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            out_reg     <= out_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
        end
    end

    assign in_ready   = ready_reg;
    assign out        = out_reg;
    assign busy       = busy_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo: a timeline model (byte queue plus
// "line free at edge N") predicts out/busy/in_ready/fifo_count after every clock edge.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    int         sb = 1;

    logic       v1, v2, r1, r2, o1, o2, b1, b2;
    logic [2:0] c1, c2;
    logic       obs_out, obs_ready, obs_busy;
    logic [2:0] obs_cnt;

    assign v1 = in_valid && (sb == 1);
    assign v2 = in_valid && (sb == 2);
    assign obs_out   = (sb == 2) ? o2 : o1;
    assign obs_ready = (sb == 2) ? r2 : r1;
    assign obs_busy  = (sb == 2) ? b2 : b1;
    assign obs_cnt   = (sb == 2) ? c2 : c1;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(DB), .STOP_BITS(1), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v1),
        .in_ready(r1), .out(o1), .busy(b1), .fifo_count(c1));

    uart_tx_fifo #(.DATA_BITS(DB), .STOP_BITS(2), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v2),
        .in_ready(r2), .out(o2), .busy(b2), .fifo_count(c2));

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] cur_byte;
    int         cyc, start_edge, free_edge, max_cnt;
    bit         m_ready, last_push;

    task automatic model_reset();
        mq.delete();
        cyc = 0; start_edge = 0; free_edge = 0; max_cnt = 0;
        m_ready = 1'b0; last_push = 1'b0; cur_byte = 8'h00;
    endtask

    task automatic step();
        int  fl, o, slot;
        bit  push, pop;
        logic exp_out, exp_busy;
        logic [2:0] exp_cnt;
        fl = (1 + DB + sb) * C;
        @(posedge clk);
        cyc++;
        push = in_valid && m_ready;
        pop  = (cyc >= free_edge) && (mq.size() > 0);
        if (pop) begin
            cur_byte   = mq.pop_front();
            start_edge = cyc;
            free_edge  = cyc + fl;
        end
        if (push) mq.push_back(in_data);
        m_ready   = (mq.size() < DEPTH);
        last_push = push;
        #1;
        exp_out = 1'b1;
        if (cyc < free_edge) begin
            o    = cyc - start_edge;
            slot = o / C;
            if (slot == 0)        exp_out = 1'b0;
            else if (slot <= DB)  exp_out = cur_byte[slot-1];
        end
        exp_busy = (cyc < free_edge) || (mq.size() > 0);
        exp_cnt  = 3'(mq.size());
        if (int'(obs_cnt) > max_cnt) max_cnt = int'(obs_cnt);
        compared += 4;
        if (obs_out !== exp_out) begin
            mismatched++;
            $display("FAIL out cyc=%0d sb=%0d got=%b exp=%b", cyc, sb, obs_out, exp_out);
        end
        if (obs_busy !== exp_busy) begin
            mismatched++;
            $display("FAIL busy cyc=%0d sb=%0d got=%b exp=%b", cyc, sb, obs_busy, exp_busy);
        end
        if (obs_ready !== m_ready) begin
            mismatched++;
            $display("FAIL in_ready cyc=%0d sb=%0d got=%b exp=%b", cyc, sb, obs_ready, m_ready);
        end
        if (obs_cnt !== exp_cnt) begin
            mismatched++;
            $display("FAIL fifo_count cyc=%0d sb=%0d got=%0d exp=%0d", cyc, sb, obs_cnt, exp_cnt);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (((cyc < free_edge) || (mq.size() > 0)) && n < 2000) begin
            step();
            n++;
        end
        step();
        compared++;
        if (n >= 2000) begin
            mismatched++;
            $display("FAIL drain_timeout got=%0d cycles exp<2000", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        compared += 4;
        if ({o1, o2} !== 2'b11) begin mismatched++; $display("FAIL rst_out got=%b exp=11", {o1, o2}); end
        if ({r1, r2} !== 2'b00) begin mismatched++; $display("FAIL rst_ready got=%b exp=00", {r1, r2}); end
        if ({b1, b2} !== 2'b00) begin mismatched++; $display("FAIL rst_busy got=%b exp=00", {b1, b2}); end
        if ({c1, c2} !== 6'd0)  begin mismatched++; $display("FAIL rst_count got=%0d/%0d exp=0", c1, c2); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        compared++;
        if ({r1, r2} !== 2'b11) begin mismatched++; $display("FAIL ready_after_rst got=%b exp=11", {r1, r2}); end
    endtask

    task automatic measure_frame(input logic [7:0] b, input int exp_len);
        int s, f, n;
        s = -1; f = -1; n = 0;
        in_valid = 1'b1; in_data = b;
        step();
        in_valid = 1'b0;
        while (f < 0 && n < 200) begin
            step();
            if (s < 0 && obs_out === 1'b0) s = cyc;
            if (s >= 0 && obs_busy === 1'b0) f = cyc;
            n++;
        end
        compared++;
        if (f - s != exp_len) begin
            mismatched++;
            $display("FAIL frame_len byte=%h got=%0d exp=%0d", b, f - s, exp_len);
        end
        drain();
    endtask

    task automatic test_single();
        sb = 1;
        measure_frame(8'hA5, (1 + DB + 1) * C);
    endtask

    task automatic test_back_to_back();
        sb = 1;
        max_cnt = 0;
        in_valid = 1'b1; in_data = 8'h00;
        step();
        in_data = 8'hFF;
        step();
        compared++;
        if (obs_cnt !== 3'd1) begin
            mismatched++;
            $display("FAIL simul_push_pop got=%0d exp=1", obs_cnt);
        end
        in_valid = 1'b0;
        drain();
        compared++;
        if (max_cnt != 1) begin
            mismatched++;
            $display("FAIL b2b_peak got=%0d exp=1", max_cnt);
        end
    endtask

    task automatic test_full();
        int idx, n;
        sb = 1;
        max_cnt = 0;
        idx = 0; n = 0;
        in_valid = 1'b1;
        while (idx < 6 && n < 500) begin
            in_data = 8'h11 + 8'(idx);
            step();
            if (last_push) idx++;
            n++;
        end
        in_valid = 1'b0;
        drain();
        compared++;
        if (max_cnt != DEPTH) begin
            mismatched++;
            $display("FAIL full_peak got=%0d exp=%0d", max_cnt, DEPTH);
        end
    endtask

    task automatic test_stop2();
        sb = 2;
        measure_frame(8'h3C, (1 + DB + 2) * C);
        sb = 1;
    endtask

    task automatic test_random(input int s);
        sb = s;
        for (int i = 0; i < 250; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            step();
        end
        drain();
        sb = 1;
    endtask

    task automatic test_reset_mid();
        int n;
        sb = 1;
        n = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        while ((cyc - start_edge) != (4 + 3 * C + 1) && n < 200) begin
            step();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        compared += 4;
        if (o1 !== 1'b1)  begin mismatched++; $display("FAIL mid_rst_out got=%b exp=1", o1); end
        if (r1 !== 1'b0)  begin mismatched++; $display("FAIL mid_rst_ready got=%b exp=0", r1); end
        if (c1 !== 3'd0)  begin mismatched++; $display("FAIL mid_rst_count got=%0d exp=0", c1); end
        if (b1 !== 1'b0)  begin mismatched++; $display("FAIL mid_rst_busy got=%b exp=0", b1); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 60; i++) step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stop2();
        test_random(1);
        test_random(2);
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
